// File: rtl/connect_four_pkg.sv
// Shared board geometry, cell encoding and renderer state encoding for the
// connect-four LED renderer.
package connect_four_pkg;

  localparam int unsigned COLS  = 7;
  localparam int unsigned ROWS  = 6;
  localparam int unsigned CELLS = COLS * ROWS;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BIT,
    LATCH
  } state_t;

endpackage

// File: rtl/led_bit_tx.sv
// Single WS2812-style bit transmitter: one start pulse sends one TBIT-cycle
// symbol whose high time is T0H or T1H; done is high on the symbol's last cycle.
module led_bit_tx #(
  parameter int unsigned T0H  = 4,
  parameter int unsigned T1H  = 8,
  parameter int unsigned TBIT = 12
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_in,
  output logic led,
  output logic done
);

  localparam int unsigned PW = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam logic [PW-1:0] LAST = PW'(TBIT - 1);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_nx;
  logic          busy;
  logic          hi;

  assign phase_nx = phase + PW'(1);

  // A start on the last phase chains the next symbol with no gap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
      busy  <= 1'b0;
      hi    <= 1'b0;
      led   <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      phase <= '0;
      busy  <= 1'b1;
      hi    <= bit_in;
      led   <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      if (phase == LAST) begin
        busy <= 1'b0;
        led  <= 1'b0;
        done <= 1'b0;
      end else begin
        phase <= phase_nx;
        led   <= hi ? (32'(phase_nx) < T1H) : (32'(phase_nx) < T0H);
        done  <= (phase_nx == LAST);
      end
    end else begin
      led  <= 1'b0;
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/connect_four_led_renderer.sv
// Connect-four board keeper: applies column drops, alternates players and
// streams the whole 42-pixel board out as a WS2812 frame whenever it changes.
module connect_four_led_renderer
  import connect_four_pkg::*;
#(
  parameter int unsigned T0H       = 4,
  parameter int unsigned T1H       = 8,
  parameter int unsigned TBIT      = 12,
  parameter int unsigned TRESET    = 500,
  parameter logic [23:0] P1_GRB    = 24'h00FF00,
  parameter logic [23:0] P2_GRB    = 24'h0000FF,
  parameter logic [23:0] EMPTY_GRB = 24'h000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] col,
  output logic       led,
  output logic       ready,
  output logic       player,
  output logic       board_full
);

  localparam int unsigned RW = $clog2(TRESET + 1);

  cell_t       board  [CELLS];
  logic [2:0]  height [COLS];
  logic [5:0]  filled;
  logic [2:0]  col_prev;
  logic [2:0]  col_idx;
  logic [2:0]  hgt;
  logic [5:0]  cell_idx;
  logic        accept;

  state_t      state;
  logic        dirty;
  logic [5:0]  pix;
  logic [4:0]  bitcnt;
  logic [23:0] shreg;
  logic [RW-1:0] rcnt;
  logic [23:0] load_grb;
  logic        tx_start;
  logic        tx_bit;
  logic        tx_done;

  function automatic logic [23:0] cell_grb(input cell_t c);
    case (c)
      P1:      return P1_GRB;
      P2:      return P2_GRB;
      default: return EMPTY_GRB;
    endcase
  endfunction

  // Rising edge of "any button" into a non-full column.
  assign col_idx  = col - 3'd1;
  assign hgt      = height[col_idx];
  assign cell_idx = 6'(hgt) * 6'(COLS) + 6'(col_idx);
  assign accept   = (col != 3'd0) && (col_prev == 3'd0) && !board_full &&
                    (hgt < 3'(ROWS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CELLS; i++) board[i] <= EMPTY;
      for (int unsigned j = 0; j < COLS; j++) height[j] <= '0;
      filled     <= '0;
      col_prev   <= '0;
      player     <= 1'b0;
      board_full <= 1'b0;
    end else begin
      col_prev <= col;
      if (accept) begin
        board[cell_idx] <= player ? P2 : P1;
        height[col_idx] <= hgt + 3'd1;
        filled          <= filled + 6'd1;
        player          <= ~player;
        board_full      <= (filled == 6'(CELLS - 1));
      end
    end
  end

  // Colour is taken from the live board, so late drops show in later pixels.
  assign load_grb = cell_grb(board[pix]);
  assign tx_start = (state == LOAD) || ((state == BIT) && tx_done && (bitcnt != 5'd0));
  assign tx_bit   = (state == LOAD) ? load_grb[23] : shreg[23];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ready  <= 1'b0;
      dirty  <= 1'b1;
      pix    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      rcnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b1;
          if (dirty) begin
            state <= LOAD;
            ready <= 1'b0;
            dirty <= 1'b0;
            pix   <= '0;
          end
        end
        LOAD: begin
          shreg  <= {load_grb[22:0], 1'b0};
          bitcnt <= 5'd23;
          state  <= BIT;
        end
        BIT: begin
          if (tx_done) begin
            if (bitcnt != 5'd0) begin
              shreg  <= shreg << 1;
              bitcnt <= bitcnt - 5'd1;
            end else if (pix < 6'(CELLS - 1)) begin
              pix   <= pix + 6'd1;
              state <= LOAD;
            end else begin
              rcnt  <= RW'(TRESET - 1);
              state <= LATCH;
            end
          end
        end
        LATCH: begin
          if (rcnt == '0) begin
            state <= IDLE;
            ready <= 1'b1;
          end else begin
            rcnt <= rcnt - RW'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // A drop racing the IDLE->LOAD hand-off still earns a follow-up frame.
      if (accept) dirty <= 1'b1;
    end
  end

  led_bit_tx #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (tx_start),
    .bit_in(tx_bit),
    .led   (led),
    .done  (tx_done)
  );

endmodule

// File: doc/connect_four_led_renderer.md
Name: connect_four_led_renderer

Overview:
- Consumer end of the `col` drop interface produced by the four-connect button encoder.
- Holds the 7-column × 6-row two-player board and applies each drop to the lowest free cell.
- Alternates players on each accepted drop.
- Re-serialises the whole board as a WS2812-style single-wire bitstream on `led`; `ready` is high whenever no frame is in flight.

Parameters:
- T0H, 4, clock cycles `led` stays high for a 0 bit
- T1H, 8, clock cycles `led` stays high for a 1 bit
- TBIT, 12, total clock cycles per bit (must be > T1H)
- TRESET, 500, low cycles appended after the last pixel (latch gap)
- P1_GRB, 24'h00FF00, colour for player-1 cells (GRB order)
- P2_GRB, 24'h0000FF, colour for player-2 cells
- EMPTY_GRB, 24'h000000, colour for empty cells

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- col  in  3  0 = no button; 1..7 = column pressed (held while pressed)
- led  out  1  serial LED data line
- ready  out  1  1 = idle, no frame being transmitted
- player  out  1  player owning the next drop (0 = P1, 1 = P2)
- board_full  out  1  1 = all 42 cells occupied

Behaviour:
- Reset (clk edge with rst_n = 0):
  - board all empty; all column heights 0
  - player = 0, board_full = 0, led = 0, ready = 0
  - col_prev = 0; dirty = 1
  - The first frame after reset therefore blanks the strip.
- Reset mid-frame aborts immediately: led = 0 on the next cycle, with no partial-bit completion.
- Drop detection:
  - A drop is accepted on the cycle where col != 0 and col_prev == 0; col_prev is registered every cycle.
  - Changing from one nonzero col value to another nonzero value is not a new drop.
  - Holding col nonzero gives exactly one drop.
- Drop application:
  - Target cell is (row = height[col-1], column = col-1); row 0 is the bottom.
  - Applied on the edge that samples the drop; the cell is visible and player toggles the next cycle.
  - height increments by 1 (range 0..6).
  - If height == 6 (column full): the drop is ignored. No cell change, no player toggle, dirty not set.
- board_full = 1 once the total occupied count reaches 42. It remains 1 until reset; every further drop is ignored.
- Any accepted drop sets dirty. Drops are accepted at any time, including during a frame.
- FSM states:
  - IDLE: ready = 1, led = 0. If dirty, go to LOAD and clear dirty; ready falls on that transition.
  - LOAD: 1 cycle. Latch the 24-bit colour of pixel p into the shift register; bit count = 23.
    - Pixel p = row*7 + column, p = 0..41.
    - The colour is sampled from the live board at LOAD time, so a drop mid-frame may appear in later pixels.
  - BIT: TBIT cycles per bit, MSB first.
    - led = 1 for the first T0H cycles (bit = 0) or T1H cycles (bit = 1), then 0.
    - After bit 0: go to LOAD if p < 41 (p++), else go to LATCH.
  - LATCH: led = 0 for TRESET cycles, then IDLE.
    - If dirty was set during the frame, IDLE immediately starts the next frame. One idle cycle with ready = 1 is visible between frames.
- Frame length from LOAD of p0 to IDLE: 42*(1 + 24*TBIT) + TRESET cycles, which is 12638 at the defaults.
- Multiple drops during one frame coalesce into a single follow-up frame.
- Counters:
  - bit-phase counter: ceil(log2(TBIT)) bits
  - pixel counter: 6 bits
  - reset counter: ceil(log2(TRESET+1)) bits
  - No wrap occurs: all counters reload in LOAD or LATCH.

Decomposition:
- Shared package `connect_four_pkg`:
  - COLS = 7, ROWS = 6, CELLS = 42
  - cell encoding: EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10
  - renderer FSM state enum: IDLE, LOAD, BIT, LATCH
- One natural sub-module `led_bit_tx`:
  - input bit + start, output `led` pulse and done, timed by T0H/T1H/TBIT
  - The renderer owns the board, pixel sequencing and the latch gap.

Test Plan:
- Reset release, no input → ready = 0 for 12638 cycles, led shows 42×24 zero bits (4-cycle highs), then ready = 1 and stays 1.
- col 0→1→0 while idle → cell (0,0) = P1, player = 1, next frame pixel 0 = 24'h00FF00 and pixels 1–41 = 0.
- col = 3 held for 100 cycles → exactly one drop; height[2] = 1, single frame.
- Seven pulses on col = 5 → six cells alternate P1/P2 in rows 0–5 of column 4; the seventh is ignored, so player is unchanged and no extra frame is sent.
- Two drops (col 2, then col 6) issued mid-frame → exactly one follow-up frame containing both; ready shows one high cycle between frames.
- Fill all 42 cells → board_full = 1; a further pulse on col = 1 → no change; rst_n low mid-frame → led = 0 next cycle, board cleared.
